gate_classifier: RTL and testbench

Sequential tester that sits on the opposite side of the two-input MUX-based gate blocks: it drives the A/B inputs of a gate-under-test, sweeps all four input combinations, and samples the gate output for each. It assembles the 4-entry truth table and decodes it to one of AND, OR, NAND, NOR, XOR, XNOR, or "unknown". It is used as a self-check engine for the gate library and as a reusable stimulus/response block for bring-up benches.

---
 rtl/gate_classifier.sv | 111 +++++++++++
 tb/tb_gate_classifier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_classifier.sv
// Sweeps all four {A,B} vectors into a two-input gate-under-test, samples its
// output for each, and decodes the resulting truth table to a gate type.
module gate_classifier #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       sense_y,
   output logic       drive_a,
   output logic       drive_b,
   output logic       busy,
   output logic       done,
   output logic [3:0] truth_table,
   output logic [2:0] gate_code,
   output logic       valid_gate
);

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      DECODE = 2'd2
   } state_t;

   state_t     state_r;
   logic [1:0] idx_r;
   logic [3:0] cnt_r;
   logic [3:0] tt_shadow_r;

   // Truth table bit i holds Y for {A,B} = i; anything unrecognised maps to 0.
   function automatic logic [2:0] decode_gate(input logic [3:0] tt);
      logic [2:0] code;
      case (tt)
         4'b1000: code = 3'd1;
         4'b1110: code = 3'd2;
         4'b0111: code = 3'd3;
         4'b0001: code = 3'd4;
         4'b0110: code = 3'd5;
         4'b1001: code = 3'd6;
         default: code = 3'd0;
      endcase
      return code;
   endfunction

   // Sweep sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= 2'd0;
         cnt_r       <= 4'd0;
         tt_shadow_r <= 4'd0;
         drive_a     <= 1'b0;
         drive_b     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         truth_table <= 4'd0;
         gate_code   <= 3'd0;
         valid_gate  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done    <= 1'b0;
               drive_a <= 1'b0;
               drive_b <= 1'b0;
               idx_r   <= 2'd0;
               cnt_r   <= 4'd0;
               if (start) begin
                  state_r     <= SWEEP;
                  busy        <= 1'b1;
                  tt_shadow_r <= 4'd0;
               end else begin
                  busy <= 1'b0;
               end
            end
            SWEEP: begin
               if (cnt_r == SETTLE) begin
                  // Drives already hold idx_r, so sense_y reflects this vector.
                  tt_shadow_r[idx_r] <= sense_y;
                  if (idx_r == 2'd3) begin
                     state_r <= DECODE;
                  end else begin
                     idx_r              <= idx_r + 2'd1;
                     cnt_r              <= 4'd0;
                     {drive_a, drive_b} <= idx_r + 2'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            DECODE: begin
               truth_table <= tt_shadow_r;
               gate_code   <= decode_gate(tt_shadow_r);
               valid_gate  <= (decode_gate(tt_shadow_r) != 3'd0);
               done        <= 1'b1;
               busy        <= 1'b0;
               drive_a     <= 1'b0;
               drive_b     <= 1'b0;
               state_r     <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_classifier.sv
// Scoreboard bench for gate_classifier: three instances (S = 1, 0, 15) each
// driving a modelled gate-under-test described by its 4-bit truth table.
module tb_gate_classifier;

   logic       clk = 1'b0;
   logic       rst_v[3];
   logic       start_v[3];
   logic       sense_v[3];
   logic       da_v[3];
   logic       db_v[3];
   logic       busy_v[3];
   logic       done_v[3];
   logic [3:0] tt_v[3];
   logic [2:0] code_v[3];
   logic       valid_v[3];
   logic [3:0] gut[3];

   int sv[3] = '{1, 0, 15};
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         inst;
      logic [3:0] tt;
      logic [2:0] code;
      logic       valid;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int i = 0; i < 3; i++) sense_v[i] = gut[i][{da_v[i], db_v[i]}];
   end

   gate_classifier #(.SETTLE_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sense_y(sense_v[0]),
      .drive_a(da_v[0]), .drive_b(db_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .truth_table(tt_v[0]), .gate_code(code_v[0]), .valid_gate(valid_v[0]));

   gate_classifier #(.SETTLE_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sense_y(sense_v[1]),
      .drive_a(da_v[1]), .drive_b(db_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .truth_table(tt_v[1]), .gate_code(code_v[1]), .valid_gate(valid_v[1]));

   gate_classifier #(.SETTLE_CYCLES(15)) dut2 (
      .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .sense_y(sense_v[2]),
      .drive_a(da_v[2]), .drive_b(db_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .truth_table(tt_v[2]), .gate_code(code_v[2]), .valid_gate(valid_v[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done_v[i] === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].inst != i) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done inst=%0d actual=1 expected=0 at cycle %0d", i, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("truth_table", 32'(tt_v[i]), 32'(e.tt));
               chk("gate_code", 32'(code_v[i]), 32'(e.code));
               chk("valid_gate", 32'(valid_v[i]), 32'(e.valid));
               chk("done_latency", 32'(cyc), 32'(e.cyc));
               chk("busy_with_done", 32'(busy_v[i]), 32'd0);
            end
         end
      end
   end

   task automatic wait_done(input int inst);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_v[inst] === 1'b1) return;
      end
      checks++;
      errors++;
      $display("FAIL done_timeout inst=%0d actual=no_done expected=done", inst);
   endtask

   // Called at the negedge right after the accepting edge (cyc == E0).
   task automatic push_exp(input int inst, input logic [3:0] tt, input logic [2:0] code);
      exp_t e;
      e.inst  = inst;
      e.tt    = tt;
      e.code  = code;
      e.valid = (code != 3'd0);
      e.cyc   = cyc + 4 * (sv[inst] + 1) + 1;
      exp_q.push_back(e);
   endtask

   task automatic run_sweep(input int inst, input logic [3:0] tt, input logic [2:0] code,
                            input bit hold_chk);
      gut[inst] = tt;
      start_v[inst] = 1'b1;
      @(negedge clk);
      start_v[inst] = 1'b0;
      push_exp(inst, tt, code);
      if (hold_chk) begin
         for (int k = 0; k < 4 * (sv[inst] + 1); k++) begin
            chk("drive_vector", 32'({da_v[inst], db_v[inst]}), 32'(k / (sv[inst] + 1)));
            @(negedge clk);
         end
      end
      wait_done(inst);
   endtask

   task automatic chk_zero(input int inst, input string tag);
      chk({tag, "_busy"}, 32'(busy_v[inst]), 32'd0);
      chk({tag, "_done"}, 32'(done_v[inst]), 32'd0);
      chk({tag, "_drives"}, 32'({da_v[inst], db_v[inst]}), 32'd0);
      chk({tag, "_tt"}, 32'(tt_v[inst]), 32'd0);
      chk({tag, "_code"}, 32'(code_v[inst]), 32'd0);
      chk({tag, "_valid"}, 32'(valid_v[inst]), 32'd0);
   endtask

   logic [3:0] b2b_tt[5]   = '{4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
   logic [2:0] b2b_code[5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_v[i]   = 1'b1;
         start_v[i] = 1'b0;
         gut[i]     = 4'b0000;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) chk_zero(i, "reset");
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
      @(negedge clk);

      // AND with S = 1, including the 2-cycle hold of each vector.
      run_sweep(0, 4'b1000, 3'd1, 1'b1);
      repeat (3) @(negedge clk);

      // Remaining five gates back-to-back with start held through each done.
      gut[0] = b2b_tt[0];
      start_v[0] = 1'b1;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         push_exp(0, b2b_tt[g], b2b_code[g]);
         chk("b2b_busy", 32'(busy_v[0]), 32'd1);
         if (g == 4) start_v[0] = 1'b0;
         wait_done(0);
         if (g < 4) gut[0] = b2b_tt[g + 1];
      end
      repeat (3) @(negedge clk);

      // S = 0: constant-0 gate, then a buffer of A.
      run_sweep(1, 4'b0000, 3'd0, 1'b1);
      repeat (2) @(negedge clk);
      run_sweep(1, 4'b1100, 3'd0, 1'b0);
      repeat (2) @(negedge clk);

      // A second start three cycles into a sweep must be ignored.
      gut[0] = 4'b0001;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      push_exp(0, 4'b0001, 3'd4);
      repeat (3) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0);
      repeat (12) @(negedge clk);

      // Latch XOR, then reset during vector 2 of the next sweep.
      run_sweep(0, 4'b0110, 3'd5, 1'b0);
      @(negedge clk);
      gut[0] = 4'b1000;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("vec2_drives", 32'({da_v[0], db_v[0]}), 32'd2);
      chk("vec2_busy", 32'(busy_v[0]), 32'd1);
      rst_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0] = 1'b0;
      chk_zero(0, "midreset");
      repeat (12) @(negedge clk);
      run_sweep(0, 4'b1000, 3'd1, 1'b1);

      // S = 15: 16-cycle holds and 65-cycle latency.
      run_sweep(2, 4'b1000, 3'd1, 1'b1);
      repeat (4) @(negedge clk);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
